pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter LOAD_LATENCY, default 1: cycles a load-use consumer is held, range 1-4.
REQ-002 SHALL have parameter DIV_TIMEOUT, default 40: max cycles in DIV_WAIT before error.
REQ-003 SHALL have port clk, in, 1: the single clock, rising edge.
REQ-004 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports id_rs1_addr and id_rs2_addr, in, 5 each: source registers of the instruction in decode.
REQ-006 SHALL have ports ex_rd_addr (in, 5), ex_rd_we (in, 1) and ex_is_load (in, 1): destination of the instruction in execute.
REQ-007 SHALL have ports ex_jump_req (in, 1) and ex_jump_addr (in, 32): taken branch or jump from execute.
REQ-008 SHALL have ports ex_div_start (in, 1) and div_done (in, 1): multi-cycle divide handshake.
REQ-009 SHALL have outputs hold_pc, hold_if_id, hold_id_ex, flush_if_id and flush_id_ex, 1 bit each: pipeline control.
REQ-010 SHALL have outputs jump_flag (1) and jump_addr (32): PC redirect.
REQ-011 SHALL have outputs ctrl_state (2), div_err (1, sticky) and stall_cnt (16).

Function
REQ-012 SHALL implement states RUN=0, LD_STALL=1, DIV_WAIT=2 and FLUSH=3, visible on ctrl_state.
REQ-013 SHALL detect load-use as: ex_is_load & ex_rd_we & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
REQ-014 SHALL apply priority in RUN: jump, then divide, then load-use; at most one action per cycle.
REQ-015 In RUN with ex_jump_req, SHALL assert jump_flag, jump_addr=ex_jump_addr, flush_if_id and flush_id_ex combinationally in the same cycle, then enter FLUSH.
REQ-016 In FLUSH, SHALL assert flush_if_id for exactly one cycle, then return to RUN; a jump request in FLUSH SHALL be handled as in RUN.
REQ-017 On load-use in RUN, SHALL assert hold_pc, hold_if_id and flush_id_ex in the same cycle; if LOAD_LATENCY>1, SHALL enter LD_STALL and hold for LOAD_LATENCY-1 further cycles using a down-counter, then return to RUN.
REQ-018 In RUN with ex_div_start and no jump, SHALL assert hold_pc, hold_if_id and hold_id_ex combinationally; if div_done is also high, SHALL stay in RUN, else enter DIV_WAIT.
REQ-019 In DIV_WAIT, SHALL hold all three holds until the cycle div_done=1, then return to RUN; ex_jump_req SHALL be ignored in DIV_WAIT.
REQ-020 In DIV_WAIT, SHALL count cycles; when the count reaches DIV_TIMEOUT without div_done, SHALL set div_err, release all holds and return to RUN.
REQ-021 SHALL increment stall_cnt each cycle hold_pc=1 and saturate it at 0xFFFF.
REQ-022 When no action is taken, all outputs SHALL be 0, and jump_addr SHALL be 0 when jump_flag=0.

Reset
REQ-023 While rst_n=0: state=RUN, counters=0, div_err=0, stall_cnt=0, all control outputs=0, independent of clk.
REQ-024 Reset asserted mid-DIV_WAIT or mid-LD_STALL SHALL abort immediately, without setting div_err.

Configuration
REQ-025 With macro PIPE_CTRL_DIV_EN defined: divide handling per REQ-018 to REQ-020.
REQ-026 Without PIPE_CTRL_DIV_EN: ex_div_start and div_done are ignored, DIV_WAIT is unreachable, hold_id_ex=0 and div_err=0.

Structure
REQ-027 The state encodings, the zero-register constant (5'd0) and the hold/flush bit ordering SHALL live in the shared defines file.
REQ-028 Load-use comparison SHALL be one combinational sub-module, load_use_detect; the FSM, counters and output logic stay in pipe_ctrl.

Verification
REQ-029 Load-use: ex_is_load=1, ex_rd_we=1, ex_rd_addr=5 and id_rs2_addr=5 with LOAD_LATENCY=2 -> hold_pc=1 for 2 cycles, flush_id_ex=1 on the first, stall_cnt=2.
REQ-030 x0 and no write: ex_rd_addr=0 matching id_rs1_addr=0, or ex_rd_we=0 -> no hold.
REQ-031 Jump and load-use in the same cycle, jump_addr=0x80000010 -> jump_flag=1 and both flushes that cycle, flush_if_id the next, no hold.
REQ-032 Divide: ex_div_start, then div_done 7 cycles later -> all holds high for 8 cycles, ctrl_state=2 throughout the wait, div_err=0.
REQ-033 Timeout: ex_div_start with div_done never asserted, DIV_TIMEOUT=40 -> div_err=1 and RUN after 40 wait cycles; rst_n pulse clears it.
REQ-034 Rebuild without PIPE_CTRL_DIV_EN -> ex_div_start pulse causes no hold and ctrl_state stays 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - ctrl_state_e : controller state encoding (visible on pipe_ctrl.ctrl_state)
//   - ZERO_REG     : architectural zero register address (x0)
//   - pipe_ctl_t   : hold/flush bit ordering, MSB to LSB:
//                    hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex
//   - CTL_*        : the fixed hold/flush patterns the controller drives
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LD_STALL = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_FLUSH    = 2'd3
  } ctrl_state_e;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic hold_pc;
    logic hold_if_id;
    logic hold_id_ex;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_NONE     = '{default: 1'b0};
  // Taken jump: squash both younger instructions.
  localparam pipe_ctl_t CTL_JUMP     = '{flush_if_id: 1'b1, flush_id_ex: 1'b1, default: 1'b0};
  // Second cycle after a jump: the fetch already in flight is still wrong-path.
  localparam pipe_ctl_t CTL_FLUSH_IF = '{flush_if_id: 1'b1, default: 1'b0};
  // Load-use: freeze front end, inject a bubble into execute.
  localparam pipe_ctl_t CTL_LOAD_USE = '{hold_pc: 1'b1, hold_if_id: 1'b1, flush_id_ex: 1'b1, default: 1'b0};
  // Remaining load-latency cycles: the bubble is already in place, just keep holding.
  localparam pipe_ctl_t CTL_LD_STALL = '{hold_pc: 1'b1, hold_if_id: 1'b1, default: 1'b0};
  // Divide in flight: freeze everything up to and including execute.
  localparam pipe_ctl_t CTL_HOLD_ALL = '{hold_pc: 1'b1, hold_if_id: 1'b1, hold_id_ex: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipe_ctrl_load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
// Purely combinational load-use hazard detector. Flags when the instruction in
// execute is a load writing a non-zero register that the instruction in decode
// reads on either source port.
// Ports:
//   rs1_addr, rs2_addr : decode-stage source register addresses
//   rd_addr, rd_we     : execute-stage destination address and write enable
//   is_load            : execute-stage instruction is a load
//   load_use           : hazard detected
// -----------------------------------------------------------------------------
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  input  logic [4:0] rd_addr,
  input  logic       rd_we,
  input  logic       is_load,
  output logic       load_use
);

  // x0 is never really written, so a load targeting it cannot create a hazard.
  assign load_use = is_load && rd_we && (rd_addr != ZERO_REG) &&
                    ((rd_addr == rs1_addr) || (rd_addr == rs2_addr));

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Pipeline hazard controller: load-use stalls, jump redirect/flush and
// multi-cycle divide stalls with a timeout.
//
// Build option: define PIPE_CTRL_DIV_EN to enable divide handling. Without it
// ex_div_start/div_done are ignored, DIV_WAIT is unreachable, hold_id_ex and
// div_err stay 0.
//
// Parameters:
//   LOAD_LATENCY : cycles a load-use consumer is held (1-4)
//   DIV_TIMEOUT  : max cycles spent in DIV_WAIT before div_err is raised
// Ports:
//   clk, rst_n                         : clock (rising edge), async active-low reset
//   id_rs1_addr, id_rs2_addr           : decode-stage sources
//   ex_rd_addr, ex_rd_we, ex_is_load   : execute-stage destination
//   ex_jump_req, ex_jump_addr          : taken branch/jump from execute
//   ex_div_start, div_done             : divide handshake
//   hold_pc, hold_if_id, hold_id_ex    : stage holds
//   flush_if_id, flush_id_ex           : stage flushes
//   jump_flag, jump_addr               : PC redirect (addr is 0 when no jump)
//   ctrl_state                         : current controller state
//   div_err                            : sticky divide timeout
//   stall_cnt                          : saturating count of hold_pc cycles
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int DIV_TIMEOUT  = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_rd_we,
  input  logic        ex_is_load,
  input  logic        ex_jump_req,
  input  logic [31:0] ex_jump_addr,
  input  logic        ex_div_start,
  input  logic        div_done,
  output logic        hold_pc,
  output logic        hold_if_id,
  output logic        hold_id_ex,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        jump_flag,
  output logic [31:0] jump_addr,
  output logic [1:0]  ctrl_state,
  output logic        div_err,
  output logic [15:0] stall_cnt
);

`ifdef PIPE_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  localparam int DIV_W = $clog2(DIV_TIMEOUT + 1);

  ctrl_state_e      state, state_nxt;
  logic [1:0]       ld_cnt, ld_cnt_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic             div_err_set;
  logic             load_use;
  logic             div_go;
  pipe_ctl_t        ctl;

  load_use_detect u_load_use_detect (
    .rs1_addr (id_rs1_addr),
    .rs2_addr (id_rs2_addr),
    .rd_addr  (ex_rd_addr),
    .rd_we    (ex_rd_we),
    .is_load  (ex_is_load),
    .load_use (load_use)
  );

  // A constant-zero DIV_EN folds away the whole divide path.
  assign div_go = DIV_EN && ex_div_start;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    ld_cnt_nxt  = ld_cnt;
    div_cnt_nxt = div_cnt;
    div_err_set = 1'b0;
    ctl         = CTL_NONE;
    jump_flag   = 1'b0;
    jump_addr   = '0;
    // NOTE: outputs are combinational from the inputs, so they are also gated
    // by rst_n to read as 0 during reset regardless of clk.
    if (rst_n) begin
      case (state)
        ST_RUN, ST_FLUSH: begin
          if (state == ST_FLUSH) ctl = CTL_FLUSH_IF;
          state_nxt = ST_RUN;
          // Jump wins over everything; in FLUSH only a jump is acted upon
          // because execute holds a squashed instruction.
          if (ex_jump_req) begin
            ctl       = CTL_JUMP;
            jump_flag = 1'b1;
            jump_addr = ex_jump_addr;
            state_nxt = ST_FLUSH;
          end else if (state == ST_RUN && div_go) begin
            ctl         = CTL_HOLD_ALL;
            div_cnt_nxt = '0;
            if (!div_done) state_nxt = ST_DIV_WAIT;
          end else if (state == ST_RUN && load_use) begin
            ctl = CTL_LOAD_USE;
            if (LOAD_LATENCY > 1) begin
              state_nxt  = ST_LD_STALL;
              ld_cnt_nxt = 2'(LOAD_LATENCY - 1);
            end
          end
        end
        ST_LD_STALL: begin
          // ld_cnt holds the stall cycles still owed, including this one.
          ctl        = CTL_LD_STALL;
          ld_cnt_nxt = ld_cnt - 2'd1;
          if (ld_cnt == 2'd1) state_nxt = ST_RUN;
        end
        ST_DIV_WAIT: begin
          // Jumps are ignored here: the divide ahead of them has not retired.
          ctl = CTL_HOLD_ALL;
          if (div_done) begin
            state_nxt = ST_RUN;
          end else if (div_cnt == DIV_W'(DIV_TIMEOUT - 1)) begin
            // Last allowed wait cycle without completion: give up and flag it.
            state_nxt   = ST_RUN;
            div_err_set = 1'b1;
          end else begin
            div_cnt_nxt = div_cnt + DIV_W'(1);
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      ld_cnt    <= '0;
      div_cnt   <= '0;
      div_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state   <= state_nxt;
      ld_cnt  <= ld_cnt_nxt;
      div_cnt <= div_cnt_nxt;
      if (div_err_set) div_err <= 1'b1;
      if (ctl.hold_pc && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign hold_pc     = ctl.hold_pc;
  assign hold_if_id  = ctl.hold_if_id;
  assign hold_id_ex  = ctl.hold_id_ex;
  assign flush_if_id = ctl.flush_if_id;
  assign flush_id_ex = ctl.flush_id_ex;
  assign ctrl_state  = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Self-checking bench for pipe_ctrl (LOAD_LATENCY=2, DIV_TIMEOUT=40). Directed
// scenarios followed by randomized stimulus, all compared every cycle against a
// behavioural model built from pending-work counters rather than a state
// machine. Divide scenarios follow the PIPE_CTRL_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int LOAD_LATENCY = 2;
  localparam int DIV_TIMEOUT  = 40;
`ifdef PIPE_CTRL_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        ex_rd_we, ex_is_load, ex_jump_req, ex_div_start, div_done;
  logic [31:0] ex_jump_addr;
  logic        hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_flag;
  logic [31:0] jump_addr;
  logic [1:0]  ctrl_state;
  logic        div_err;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(
    .LOAD_LATENCY (LOAD_LATENCY),
    .DIV_TIMEOUT  (DIV_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1_addr  (id_rs1_addr),
    .id_rs2_addr  (id_rs2_addr),
    .ex_rd_addr   (ex_rd_addr),
    .ex_rd_we     (ex_rd_we),
    .ex_is_load   (ex_is_load),
    .ex_jump_req  (ex_jump_req),
    .ex_jump_addr (ex_jump_addr),
    .ex_div_start (ex_div_start),
    .div_done     (div_done),
    .hold_pc      (hold_pc),
    .hold_if_id   (hold_if_id),
    .hold_id_ex   (hold_id_ex),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .jump_flag    (jump_flag),
    .jump_addr    (jump_addr),
    .ctrl_state   (ctrl_state),
    .div_err      (div_err),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    bit          jreq;
    logic [31:0] jaddr;
    bit          ld;
    bit          we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    bit          dstart;
    bit          ddone;
  } stim_t;

  int n_cmp = 0;
  int n_mis = 0;

  // Model: outstanding work expressed as counts, not states.
  int m_ld_left;    // load stall cycles still owed after the detecting cycle
  bit m_div_busy;   // a divide is being waited on
  int m_div_waited; // wait cycles spent on the current divide
  bit m_flush;      // a wrong-path fetch still has to be squashed
  bit m_err;
  int m_stall;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] ctl_vec();
    return {hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, jump_flag};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.jreq = 0; s.jaddr = '0; s.ld = 0; s.we = 0;
    s.rd = '0; s.rs1 = '0; s.rs2 = '0; s.dstart = 0; s.ddone = 0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    ex_jump_req  = s.jreq;
    ex_jump_addr = s.jaddr;
    ex_is_load   = s.ld;
    ex_rd_we     = s.we;
    ex_rd_addr   = s.rd;
    id_rs1_addr  = s.rs1;
    id_rs2_addr  = s.rs2;
    ex_div_start = s.dstart;
    div_done     = s.ddone;
  endtask

  // Asserts reset with busy inputs to show outputs are forced low, then
  // releases it on a falling edge. Leaves time at posedge+1.
  task automatic apply_reset();
    stim_t s;
    s = idle();
    s.jreq = 1; s.jaddr = 32'hDEAD_BEEF; s.ld = 1; s.we = 1;
    s.rd = 5'd3; s.rs1 = 5'd3; s.dstart = 1;
    drive(s);
    rst_n = 1'b0;
    #1;
    check("rst_ctl",   ctl_vec(),  6'd0);
    check("rst_jaddr", jump_addr,  32'd0);
    check("rst_state", ctrl_state, 2'd0);
    check("rst_stall", stall_cnt,  16'd0);
    check("rst_err",   div_err,    1'b0);
    drive(idle());
    m_ld_left = 0; m_div_busy = 0; m_div_waited = 0; m_flush = 0; m_err = 0; m_stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: drive, compute expectations, compare mid-cycle, advance.
  task automatic run_cycle(input stim_t s);
    bit          hp, hi, he, fi, fe, jf, lu;
    logic [31:0] e_addr;
    logic [1:0]  e_state;
    logic [15:0] e_stall;
    bit          e_err;
    drive(s);
    e_state = (m_ld_left > 0) ? 2'd1 : m_div_busy ? 2'd2 : m_flush ? 2'd3 : 2'd0;
    e_stall = 16'(m_stall);
    e_err   = m_err;
    {hp, hi, he, fi, fe, jf} = '0;
    e_addr = '0;
    lu = s.ld && s.we && s.rd != 5'd0 && (s.rd == s.rs1 || s.rd == s.rs2);
    if (m_ld_left > 0) begin
      hp = 1; hi = 1;
      m_ld_left--;
    end else if (m_div_busy) begin
      hp = 1; hi = 1; he = 1;
      m_div_waited++;
      if (s.ddone) m_div_busy = 0;
      else if (m_div_waited == DIV_TIMEOUT) begin
        m_div_busy = 0;
        m_err = 1;
      end
    end else begin
      fi = m_flush;
      if (s.jreq) begin
        jf = 1; e_addr = s.jaddr; fi = 1; fe = 1;
      end else if (!m_flush && DIV_EN && s.dstart) begin
        hp = 1; hi = 1; he = 1;
        if (!s.ddone) begin
          m_div_busy = 1;
          m_div_waited = 0;
        end
      end else if (!m_flush && lu) begin
        hp = 1; hi = 1; fe = 1;
        m_ld_left = LOAD_LATENCY - 1;
      end
      m_flush = s.jreq;
    end
    #2;
    check("ctl",   ctl_vec(),  {hp, hi, he, fi, fe, jf});
    check("jaddr", jump_addr,  e_addr);
    check("state", ctrl_state, e_state);
    check("stall", stall_cnt,  e_stall);
    check("err",   div_err,    e_err);
    if (hp && m_stall < 16'hFFFF) m_stall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    drive(idle());
    apply_reset();

    // Load-use on rs2 with LOAD_LATENCY=2: two hold cycles, bubble on the first.
    s = idle(); s.ld = 1; s.we = 1; s.rd = 5'd5; s.rs1 = 5'd9; s.rs2 = 5'd5;
    run_cycle(s);
    run_cycle(idle());
    run_cycle(idle());
    check("lu_stall_cnt", stall_cnt, 16'd2);

    // x0 destination and non-writing load never stall.
    s = idle(); s.ld = 1; s.we = 1; s.rd = 5'd0; s.rs1 = 5'd0;
    run_cycle(s);
    s = idle(); s.ld = 1; s.we = 0; s.rd = 5'd7; s.rs1 = 5'd7;
    run_cycle(s);

    // Jump together with a load-use: jump wins, flush_if_id repeats next cycle.
    s = idle(); s.jreq = 1; s.jaddr = 32'h8000_0010;
    s.ld = 1; s.we = 1; s.rd = 5'd4; s.rs1 = 5'd4;
    run_cycle(s);
    run_cycle(idle());
    run_cycle(idle());
    check("jump_no_stall", stall_cnt, 16'd2);

    // Back-to-back jumps: the second is taken while in FLUSH.
    s = idle(); s.jreq = 1; s.jaddr = 32'h0000_1000;
    run_cycle(s);
    s.jaddr = 32'h0000_2000;
    run_cycle(s);
    run_cycle(idle());
    run_cycle(idle());

    // Reset in the middle of a load stall aborts it at once.
    s = idle(); s.ld = 1; s.we = 1; s.rd = 5'd6; s.rs1 = 5'd6;
    run_cycle(s);
    check("in_ld_stall", ctrl_state, 2'd1);
    apply_reset();

`ifdef PIPE_CTRL_DIV_EN
    // Divide completing 7 cycles after start: 8 hold cycles, no error.
    s = idle(); s.dstart = 1;
    run_cycle(s);
    for (int i = 0; i < 6; i++) run_cycle(idle());
    s = idle(); s.ddone = 1;
    run_cycle(s);
    run_cycle(idle());
    check("div_stall_cnt", stall_cnt, 16'd8);
    check("div_no_err", div_err, 1'b0);

    // Timeout: 40 wait cycles without div_done.
    apply_reset();
    s = idle(); s.dstart = 1;
    run_cycle(s);
    for (int i = 0; i < DIV_TIMEOUT; i++) run_cycle(idle());
    check("to_state", ctrl_state, 2'd0);
    check("to_err", div_err, 1'b1);
    check("to_stall", stall_cnt, 16'(DIV_TIMEOUT + 1));
    run_cycle(idle());
    apply_reset();

    // Reset mid-wait must not raise div_err.
    s = idle(); s.dstart = 1;
    run_cycle(s);
    for (int i = 0; i < 3; i++) run_cycle(idle());
    apply_reset();
`else
    // Divide handling compiled out: start pulse does nothing.
    s = idle(); s.dstart = 1;
    run_cycle(s);
    run_cycle(idle());
    check("nodiv_state", ctrl_state, 2'd0);
    check("nodiv_stall", stall_cnt, 16'd0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) apply_reset();
      s.jreq   = ($urandom_range(0, 7) == 0);
      s.jaddr  = $urandom;
      s.ld     = $urandom_range(0, 1) == 1;
      s.we     = ($urandom_range(0, 3) != 0);
      s.rd     = 5'($urandom_range(0, 3));
      s.rs1    = 5'($urandom_range(0, 3));
      s.rs2    = 5'($urandom_range(0, 3));
      s.dstart = ($urandom_range(0, 9) == 0);
      s.ddone  = ($urandom_range(0, 3) == 0);
      run_cycle(s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
